bram_bank_array: RTL and testbench

Parametrised successor to the fixed three-bank byte-masked BRAM group used in the sliding-window buffer. It provides NUM_BANK independent simple-dual-port banks. Each bank has its own write-address counter with modulo-DEPTH wrap, a sticky wrap flag, and a group write enable with per-byte masks. Reads are registered with a qualifying valid. The block sits between the window-fill controller, which drives the writes and counters, and the window-read datapath, which drives per-bank read addresses.

---
 rtl/bram_bank_array.sv | 135 +++++++++++++
 tb/tb_bram_bank_array.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_bank_array.sv
// bram_bank_array: NUM_BANK independent simple-dual-port byte-masked banks.
// Each bank has a write pointer with modulo-DEPTH wrap and a sticky wrap flag.
// All banks share one group write enable and one read strobe.
// Reads are registered with a qualifying valid.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_data           write word, bank b in [8*BYTES*(b+1)-1 : 8*BYTES*b]
//   wr_data_mask      byte enables, bit BYTES*b+i -> byte i of bank b
//   wr_data_group_en  write enable for all banks
//   wr_addr_inc       per-bank write-pointer increment
//   wr_addr_reset     synchronous clear of all pointers and wrap flags
//   rd_en             read strobe for all banks
//   rd_addr           per-bank read addresses, bank 0 in the LSBs
//   cur_addr          current write pointers, bank 0 in the LSBs
//   wrap_flag         sticky per-bank wrap indication
//   rd_data_out       registered read data
//   rd_valid          rd_data_out belongs to the rd_en of the previous cycle
//
// Configuration macro BRAM_BANK_BYPASS_EN:
//   defined   -> write-first on a read/write collision (written bytes forwarded)
//   undefined -> read-first (old memory word returned)
module bram_bank_array #(
    parameter int unsigned NUM_BANK = 3,
    parameter int unsigned BYTES    = 8,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8*BYTES*NUM_BANK-1:0]   wr_data,
    input  logic [BYTES*NUM_BANK-1:0]     wr_data_mask,
    input  logic                          wr_data_group_en,
    input  logic [NUM_BANK-1:0]           wr_addr_inc,
    input  logic                          wr_addr_reset,
    input  logic                          rd_en,
    input  logic [ADDR_W*NUM_BANK-1:0]    rd_addr,
    output logic [ADDR_W*NUM_BANK-1:0]    cur_addr,
    output logic [NUM_BANK-1:0]           wrap_flag,
    output logic [8*BYTES*NUM_BANK-1:0]   rd_data_out,
    output logic                          rd_valid
);

    localparam int unsigned WORD_W = 8 * BYTES;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Read valid tracks the previous cycle's strobe; dropped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [WORD_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] ptr;
        logic              wrap;
        logic [WORD_W-1:0] wdata;
        logic [BYTES-1:0]  wmask;
        logic [ADDR_W-1:0] raddr;
        logic              raddr_ok_c;
        logic [WORD_W-1:0] rword_c;
        logic [WORD_W-1:0] rdata;

        assign wdata = wr_data[WORD_W*b +: WORD_W];
        assign wmask = wr_data_mask[BYTES*b +: BYTES];
        assign raddr = rd_addr[ADDR_W*b +: ADDR_W];

        // Write pointer: reset beats increment; wrap sets the sticky flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr  <= '0;
                wrap <= 1'b0;
            end else if (wr_addr_reset) begin
                ptr  <= '0;
                wrap <= 1'b0;
            end else if (wr_addr_inc[b]) begin
                if (ptr == LAST_ADDR) begin
                    ptr  <= '0;
                    wrap <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end

        // Byte-masked write at the pre-increment pointer; contents not reset.
        always_ff @(posedge clk) begin
            if (wr_data_group_en) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (wmask[i]) begin
                        mem[MEM_AW'(ptr)][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end

        // Read word select; out-of-range addresses read as zero.
        always_comb begin
            rword_c    = '0;
            raddr_ok_c = ({1'b0, raddr} < DEPTH_X);
            if (raddr_ok_c) begin
                rword_c = mem[MEM_AW'(raddr)];
`ifdef BRAM_BANK_BYPASS_EN
                // Forward the bytes being written this cycle to the same address.
                if (wr_data_group_en && (ptr == raddr)) begin
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        if (wmask[i]) begin
                            rword_c[8*i +: 8] = wdata[8*i +: 8];
                        end
                    end
                end
`endif
            end
        end

        // Read data register, holds while rd_en is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata <= '0;
            end else if (rd_en) begin
                rdata <= rword_c;
            end
        end

        assign cur_addr[ADDR_W*b +: ADDR_W]    = ptr;
        assign wrap_flag[b]                    = wrap;
        assign rd_data_out[WORD_W*b +: WORD_W] = rdata;
    end

endmodule

// File: tb/tb_bram_bank_array.sv
// Directed self-checking bench for bram_bank_array.
// dut_a uses the default geometry (DEPTH=512); dut_b uses DEPTH=5 for the
// wrap and out-of-range cases. Both share every input except rd_addr.
module tb_bram_bank_array;

    logic         clk;
    logic         rst_n;
    logic [191:0] wr_data;
    logic [23:0]  wr_data_mask;
    logic         wr_data_group_en;
    logic [2:0]   wr_addr_inc;
    logic         wr_addr_reset;
    logic         rd_en;
    logic [26:0]  rd_addr_a;
    logic [8:0]   rd_addr_b;

    logic [26:0]  cur_addr_a;
    logic [2:0]   wrap_flag_a;
    logic [191:0] rd_data_a;
    logic         rd_valid_a;
    logic [8:0]   cur_addr_b;
    logic [2:0]   wrap_flag_b;
    logic [191:0] rd_data_b;
    logic         rd_valid_b;

    int tests_run;
    int tests_failed;

    bram_bank_array dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_data          (wr_data),
        .wr_data_mask     (wr_data_mask),
        .wr_data_group_en (wr_data_group_en),
        .wr_addr_inc      (wr_addr_inc),
        .wr_addr_reset    (wr_addr_reset),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr_a),
        .cur_addr         (cur_addr_a),
        .wrap_flag        (wrap_flag_a),
        .rd_data_out      (rd_data_a),
        .rd_valid         (rd_valid_a)
    );

    bram_bank_array #(.NUM_BANK(3), .BYTES(8), .DEPTH(5), .ADDR_W(3)) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_data          (wr_data),
        .wr_data_mask     (wr_data_mask),
        .wr_data_group_en (wr_data_group_en),
        .wr_addr_inc      (wr_addr_inc),
        .wr_addr_reset    (wr_addr_reset),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr_b),
        .cur_addr         (cur_addr_b),
        .wrap_flag        (wrap_flag_b),
        .rd_data_out      (rd_data_b),
        .rd_valid         (rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_data = '0; wr_data_mask = '0; wr_data_group_en = 1'b0;
        wr_addr_inc = '0; wr_addr_reset = 1'b0; rd_en = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        #1;
        tests_run++;
        if (cur_addr_a !== 27'd0) begin
            $display("FAIL reset_cur_addr: got %h expected 0", cur_addr_a); tests_failed++;
        end
        tests_run++;
        if (wrap_flag_a !== 3'b000) begin
            $display("FAIL reset_wrap: got %b expected 000", wrap_flag_a); tests_failed++;
        end
        tests_run++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            $display("FAIL reset_rd_valid: got %b/%b expected 0/0", rd_valid_a, rd_valid_b); tests_failed++;
        end
        tests_run++;
        if (rd_data_a !== 192'd0) begin
            $display("FAIL reset_rd_data: got %h expected 0", rd_data_a); tests_failed++;
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_increment();
        wr_addr_inc = 3'b101;
        repeat (4) tick();
        wr_addr_inc = 3'b000;
        tests_run++;
        if (cur_addr_a !== {9'd4, 9'd0, 9'd4}) begin
            $display("FAIL inc_cur_addr: got %h expected %h", cur_addr_a, {9'd4, 9'd0, 9'd4}); tests_failed++;
        end
        tests_run++;
        if (wrap_flag_a !== 3'b000 || wrap_flag_b !== 3'b000) begin
            $display("FAIL inc_wrap: got %b/%b expected 000/000", wrap_flag_a, wrap_flag_b); tests_failed++;
        end
        tests_run++;
        if (cur_addr_b !== {3'd4, 3'd0, 3'd4}) begin
            $display("FAIL inc_cur_addr_d5: got %h expected %h", cur_addr_b, {3'd4, 3'd0, 3'd4}); tests_failed++;
        end
        wr_addr_reset = 1'b1;
        tick();
        wr_addr_reset = 1'b0;
        tests_run++;
        if (cur_addr_a !== 27'd0) begin
            $display("FAIL inc_clear: got %h expected 0", cur_addr_a); tests_failed++;
        end
    endtask

    task automatic test_masked_write();
        wr_data_group_en = 1'b1;
        wr_data = {128'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        wr_data_mask = 24'h0000FF;
        tick();
        wr_data = {128'd0, 64'h1122_3344_5566_7788};
        wr_data_mask = 24'h00000F;
        tick();
        wr_data_group_en = 1'b0;
        wr_data_mask = '0;
        rd_en = 1'b1;
        rd_addr_a = 27'd0;
        tests_run++;
        if (rd_valid_a !== 1'b0) begin
            $display("FAIL mask_valid_early: got %b expected 0", rd_valid_a); tests_failed++;
        end
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rd_data_a[63:0] !== 64'hFFFF_FFFF_5566_7788) begin
            $display("FAIL mask_data: got %h expected ffffffff55667788", rd_data_a[63:0]); tests_failed++;
        end
        tests_run++;
        if (rd_valid_a !== 1'b1) begin
            $display("FAIL mask_valid: got %b expected 1", rd_valid_a); tests_failed++;
        end
        tick();
        tests_run++;
        if (rd_valid_a !== 1'b0) begin
            $display("FAIL mask_valid_fall: got %b expected 0", rd_valid_a); tests_failed++;
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_ptr [5];
        exp_ptr[0] = 3'd1; exp_ptr[1] = 3'd2; exp_ptr[2] = 3'd3;
        exp_ptr[3] = 3'd4; exp_ptr[4] = 3'd0;
        wr_addr_inc = 3'b010;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (cur_addr_b[5:3] !== exp_ptr[i] || wrap_flag_b[1] !== (i == 4)) begin
                $display("FAIL wrap_step%0d: got ptr %0d wrap %b expected ptr %0d wrap %b",
                         i, cur_addr_b[5:3], wrap_flag_b[1], exp_ptr[i], (i == 4)); tests_failed++;
            end
        end
        wr_addr_inc = 3'b000;
        tick(); tick();
        tests_run++;
        if (wrap_flag_b !== 3'b010) begin
            $display("FAIL wrap_sticky: got %b expected 010", wrap_flag_b); tests_failed++;
        end
        wr_addr_reset = 1'b1;
        wr_addr_inc = 3'b010;
        tick();
        wr_addr_reset = 1'b0;
        wr_addr_inc = 3'b000;
        tests_run++;
        if (cur_addr_b !== 9'd0 || wrap_flag_b !== 3'b000) begin
            $display("FAIL wrap_clear: got ptr %h wrap %b expected 0 000", cur_addr_b, wrap_flag_b); tests_failed++;
        end
        tests_run++;
        if (cur_addr_a !== 27'd0) begin
            $display("FAIL wrap_clear_a: got %h expected 0", cur_addr_a); tests_failed++;
        end
    endtask

    task automatic test_collision();
        logic [63:0] exp_coll;
`ifdef BRAM_BANK_BYPASS_EN
        exp_coll = 64'h0000_0000_0000_AAAA;
`else
        exp_coll = 64'h0;
`endif
        wr_addr_inc = 3'b100;
        repeat (7) tick();
        wr_addr_inc = 3'b000;
        tests_run++;
        if (cur_addr_a[26:18] !== 9'd7) begin
            $display("FAIL coll_ptr: got %0d expected 7", cur_addr_a[26:18]); tests_failed++;
        end
        wr_data_group_en = 1'b1;
        wr_data = 192'd0;
        wr_data_mask = 24'hFF0000;
        tick();
        wr_data = {64'hAAAA_AAAA_AAAA_AAAA, 128'd0};
        wr_data_mask = 24'h030000;
        rd_en = 1'b1;
        rd_addr_a = {9'd7, 9'd0, 9'd0};
        tick();
        wr_data_group_en = 1'b0;
        wr_data_mask = '0;
        tests_run++;
        if (rd_data_a[191:128] !== exp_coll) begin
            $display("FAIL coll_same_cycle: got %h expected %h", rd_data_a[191:128], exp_coll); tests_failed++;
        end
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rd_data_a[191:128] !== 64'h0000_0000_0000_AAAA) begin
            $display("FAIL coll_next_read: got %h expected 000000000000aaaa", rd_data_a[191:128]); tests_failed++;
        end
        tests_run++;
        if (cur_addr_a[26:18] !== 9'd7) begin
            $display("FAIL coll_ptr_hold: got %0d expected 7", cur_addr_a[26:18]); tests_failed++;
        end
    endtask

    task automatic test_oor_hold();
        rd_en = 1'b1;
        rd_addr_b = {3'd0, 3'd0, 3'd6};
        tick();
        tests_run++;
        if (rd_data_b[63:0] !== 64'h0 || rd_valid_b !== 1'b1) begin
            $display("FAIL oor_zero: got %h valid %b expected 0 valid 1", rd_data_b[63:0], rd_valid_b); tests_failed++;
        end
        rd_addr_b = 9'd0;
        tick();
        tests_run++;
        if (rd_data_b[63:0] !== 64'hFFFF_FFFF_5566_7788) begin
            $display("FAIL oor_inrange: got %h expected ffffffff55667788", rd_data_b[63:0]); tests_failed++;
        end
        rd_en = 1'b0;
        rd_addr_b = {3'd0, 3'd0, 3'd6};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rd_data_b[63:0] !== 64'hFFFF_FFFF_5566_7788 || rd_valid_b !== 1'b0) begin
                $display("FAIL hold_cycle%0d: got %h valid %b expected ffffffff55667788 valid 0",
                         i, rd_data_b[63:0], rd_valid_b); tests_failed++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        rd_en = 1'b1;
        rd_addr_a = {9'd7, 9'd0, 9'd0};
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rd_valid_a !== 1'b0 || cur_addr_a !== 27'd0 || wrap_flag_b !== 3'b000) begin
            $display("FAIL midrst_clear: got valid %b ptr %h wrap %b expected 0 0 000",
                     rd_valid_a, cur_addr_a, wrap_flag_b); tests_failed++;
        end
        #1;
        rst_n = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rd_data_a[63:0] !== 64'hFFFF_FFFF_5566_7788 || rd_valid_a !== 1'b1) begin
            $display("FAIL midrst_bank0: got %h valid %b expected ffffffff55667788 valid 1",
                     rd_data_a[63:0], rd_valid_a); tests_failed++;
        end
        tests_run++;
        if (rd_data_a[191:128] !== 64'h0000_0000_0000_AAAA) begin
            $display("FAIL midrst_bank2: got %h expected 000000000000aaaa", rd_data_a[191:128]); tests_failed++;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_increment();
        test_masked_write();
        test_wrap();
        test_collision();
        test_oor_hold();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
